// File: rtl/fifo_sync_nbit_pkg.sv
// Shared definitions for the synchronous FIFO slice.
//   FIFO_WIDTH / FIFO_DEPTH : default word width and entry count
//   clog2()                 : constant function used to derive pointer width
package fifo_sync_nbit_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/muxnbit.sv
// N-way, WIDTH-bit multiplexer.
//   din  : N packed input words
//   sel  : word select (N must equal 2**SW)
//   dout : selected word
module muxnbit #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = 2
) (
  input  logic [N-1:0][WIDTH-1:0] din,
  input  logic [SW-1:0]           sel,
  output logic [WIDTH-1:0]        dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regnbit_en.sv
// WIDTH-bit register with load enable and no reset; one FIFO storage word.
//   clk  : rising-edge clock
//   en   : load d on the next edge when high
//   d    : data in
//   q    : stored word
module regnbit_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/fifo_sync_nbit.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
//   clk, reset          : clock and async active-high reset
//   in_data/in_valid    : producer word and strobe; in_ready = !full
//   out_data/out_valid  : head word (0 while empty) and strobe; out_ready from consumer
//   count               : stored words, 0..DEPTH
module fifo_sync_nbit
  import fifo_sync_nbit_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count
);

  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic [DEPTH-1:0][WIDTH-1:0] words;
  logic [WIDTH-1:0]           head;

  // Flags come from count so pointer equality never has to be disambiguated.
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  // A pop at full does not open a slot in the same cycle: no write-through.
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    regnbit_en #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .en  (push && (wr_ptr == AW'(i))),
      .d   (in_data),
      .q   (words[i])
    );
  end

  muxnbit #(.WIDTH(WIDTH), .N(DEPTH), .SW(AW)) u_head_mux (
    .din  (words),
    .sel  (rd_ptr),
    .dout (head)
  );

  // Storage is never reset, so stale or unknown words must be masked while empty.
  assign out_data = empty ? '0 : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sync_nbit.sv
module tb_fifo_sync_nbit;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_cmp;
  int n_err;

  fifo_sync_nbit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance one rising edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    logic [7:0] seq[4];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset then idle
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);

    // no same-cycle bypass while empty
    in_valid = 1'b1;
    in_data  = 8'h11;
    #1;
    check("nobypass_valid", 32'(out_valid), 32'd0);
    check("nobypass_data", 32'(out_data), 32'd0);

    // 2: fill with 11,22,33,44
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head", 32'(out_data), 32'h11);
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h55;
    step();
    check("refused_count", 32'(count), 32'd4);
    check("refused_head", 32'(out_data), 32'h11);
    in_valid = 1'b0;
    in_data  = 8'hxx;

    // 3: drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(seq[i]));
      step();
    end
    out_ready = 1'b0;
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_count", 32'(count), 32'd0);
    check("drained_data", 32'(out_data), 32'd0);
    check("drained_in_ready", 32'(in_ready), 32'd1);

    // empty pop request is ignored
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);

    // 4: ten pushes A0..A9, steady-state count 2, pointers wrap twice
    push_word(8'hA0);
    push_word(8'hA1);
    check("stream_pre_count", 32'(count), 32'd2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      in_data = 8'hA0 + 8'(i);
      check("stream_head", 32'(out_data), 32'(8'hA0 + 8'(i - 2)));
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    check("tail_head0", 32'(out_data), 32'hA8);
    step();
    check("tail_head1", 32'(out_data), 32'hA9);
    check("tail_count", 32'(count), 32'd1);
    step();
    out_ready = 1'b0;
    check("stream_empty", 32'(out_valid), 32'd0);

    // 5: push+pop at full: pop happens, push refused
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    check("full2_count", 32'(count), 32'd4);
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    out_ready = 1'b1;
    #1;
    check("full2_in_ready", 32'(in_ready), 32'd0);
    check("full2_head", 32'(out_data), 32'hB0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("full2_after_count", 32'(count), 32'd3);
    check("full2_after_ready", 32'(in_ready), 32'd1);
    check("full2_after_head", 32'(out_data), 32'hB1);

    // 6: async reset mid-cycle at count 3
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    check("areset_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_count", 32'(count), 32'd0);
    push_word(8'h5A);
    check("post_rst_head", 32'(out_data), 32'h5A);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_count1", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
